// File: rtl/spi_slave_p_pkg.sv
// Shared types for the parametrised SPI slave: latched bus mode, FSM states
// and the minimum sck half-period implied by the default synchroniser depth.
package spi_slave_p_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  // Synchroniser depth plus edge flop plus one cycle to act on the edge.
  localparam int MIN_HALF_PERIOD_CLK = DEFAULT_SYNC_STAGES + 2;

endpackage

// File: rtl/spi_slave_p_if.sv
// Core-side word interface of the SPI slave: TX holding-buffer handshake plus
// received-word and underrun pulses.
interface spi_slave_p_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             underrun;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  underrun
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output underrun
  );

endinterface

// File: rtl/spi_slave_p_sync.sv
// STAGES-deep synchroniser for an asynchronous pin plus one extra flop for
// single-cycle rise/fall pulses aligned with the synchronised level q.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_p.sv
// SPI slave with any CPOL/CPHA, MSB/LSB-first words and a one-word TX buffer; pins act
// SYNC_STAGES+1 clk after they change; tx_ready stays low while a TX word is held.
module spi_slave_p
  import spi_slave_p_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] UNDERRUN_WORD = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck,
  input  logic          ss,
  input  logic          mosi,
  output logic          miso,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          lsb_first,
  spi_slave_p_if.slave  core
);

  localparam int CW = $clog2(WIDTH);

  logic sck_q, sck_rise, sck_fall;
  logic ss_q, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_q;

  spi_mode_t  mode_l;
  logic       lsb_l;
  spi_state_t state, state_nxt;

  logic sck_edge, lead_edge, trail_edge;
  logic sample_evt, shift_evt, word_start, last_bit, tx_accept;

  logic [WIDTH-1:0] tx_sr, rx_sr, rx_sr_nxt, buf_dat, rx_word;
  logic             buf_full, rx_vld, und_pulse;
  logic [CW-1:0]    bit_cnt;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sck),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ss),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi is delayed by the same depth as sck so data lines up with its edge pulse.
  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  assign sck_edge   = sck_rise | sck_fall;
  assign lead_edge  = sck_edge & (sck_q != mode_l.cpol);
  assign trail_edge = sck_edge & (sck_q == mode_l.cpol);
  assign last_bit   = (bit_cnt == CW'(WIDTH - 1));
  assign tx_accept  = core.tx_valid & ~buf_full;
  assign rx_sr_nxt  = lsb_l ? {mosi_q, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], mosi_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_start = 1'b0;
    sample_evt = 1'b0;
    shift_evt  = 1'b0;
    case (state)
      IDLE: begin
        // cpha=1 defers the first load to the first leading edge.
        if (ss_fall) state_nxt = cpha ? SHIFT : LOAD;
      end
      LOAD: begin
        if (ss_rise) begin
          state_nxt = IDLE;
        end else begin
          word_start = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
        end else begin
          sample_evt = mode_l.cpha ? trail_edge : lead_edge;
          shift_evt  = mode_l.cpha ? lead_edge : trail_edge;
          word_start = shift_evt & (bit_cnt == '0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_l    <= '0;
      lsb_l     <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      buf_dat   <= '0;
      buf_full  <= 1'b0;
      rx_word   <= '0;
      rx_vld    <= 1'b0;
      und_pulse <= 1'b0;
    end else begin
      rx_vld    <= 1'b0;
      und_pulse <= 1'b0;

      if (state == IDLE && ss_fall) begin
        mode_l <= '{cpol: cpol, cpha: cpha};
        lsb_l  <= lsb_first;
      end

      if (word_start) begin
        if (buf_full) begin
          tx_sr <= buf_dat;
        end else begin
          tx_sr     <= UNDERRUN_WORD;
          und_pulse <= 1'b1;
        end
      end else if (shift_evt) begin
        tx_sr <= lsb_l ? (tx_sr >> 1) : (tx_sr << 1);
      end

      // A word start sees the old buffer state; an accept lands in the freed slot.
      if (tx_accept) begin
        buf_dat  <= core.tx_data;
        buf_full <= 1'b1;
      end else if (word_start && buf_full) begin
        buf_full <= 1'b0;
      end

      if (sample_evt) begin
        rx_sr <= rx_sr_nxt;
        if (last_bit) begin
          rx_word <= rx_sr_nxt;
          rx_vld  <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (state != IDLE && ss_rise) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
      end
    end
  end

  assign miso = (state != IDLE && !ss_q) ? (lsb_l ? tx_sr[0] : tx_sr[WIDTH-1]) : 1'b0;

  assign core.tx_ready = ~buf_full;
  assign core.rx_data  = rx_word;
  assign core.rx_valid = rx_vld;
  assign core.underrun = und_pulse;

endmodule

// File: tb/tb_spi_slave_p.sv
// Bench for spi_slave_p: an 8-bit instance (underrun word 0xA5) and a 16-bit instance
// share sck/mosi/mode pins; each has its own ss, miso and core interface.
module tb_spi_slave_p;
  import spi_slave_p_pkg::*;

  localparam int HP = MIN_HALF_PERIOD_CLK + 4;

  logic clk = 1'b0;
  logic rst, sck, mosi, cpol, cpha, lsb_first;
  logic ss_a, ss_b, miso_a, miso_b;

  spi_slave_p_if #(.WIDTH(8))  ifa ();
  spi_slave_p_if #(.WIDTH(16)) ifb ();

  spi_slave_p #(.WIDTH(8), .SYNC_STAGES(2), .UNDERRUN_WORD(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss_a), .mosi(mosi), .miso(miso_a),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .core(ifa)
  );

  spi_slave_p #(.WIDTH(16), .SYNC_STAGES(2), .UNDERRUN_WORD(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss_b), .mosi(mosi), .miso(miso_b),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .core(ifb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_out [8];
  logic [31:0] m_in  [8];

  logic [31:0] feed_a [128];
  logic [31:0] feed_b [128];
  int wa = 0, wb = 0, ra = 0, rb = 0;

  logic [31:0] rxq_a [$];
  logic [31:0] rxq_b [$];
  int und_a = 0, und_b = 0;

  always @(negedge clk) begin
    if (ifa.rx_valid) rxq_a.push_back({24'b0, ifa.rx_data});
    if (ifb.rx_valid) rxq_b.push_back({16'b0, ifb.rx_data});
    if (ifa.underrun) und_a++;
    if (ifb.underrun) und_b++;
  end

  // Core-side producers: one-cycle tx_valid whenever a word is queued and tx_ready is high.
  initial begin
    ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0;
    forever begin
      @(negedge clk);
      if (ifa.tx_valid) ifa.tx_valid = 1'b0;
      else if (ra < wa && ifa.tx_ready && !rst) begin
        ifa.tx_data = feed_a[ra][7:0]; ifa.tx_valid = 1'b1; ra++;
      end
      if (ifb.tx_valid) ifb.tx_valid = 1'b0;
      else if (rb < wb && ifb.tx_ready && !rst) begin
        ifb.tx_data = feed_b[rb][15:0]; ifb.tx_valid = 1'b1; rb++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [31:0] v);
    if (sel) begin feed_b[wb] = v; wb++; end
    else     begin feed_a[wa] = v; wa++; end
  endtask

  function automatic logic [31:0] rx_at(input bit sel, input int i);
    if (sel) return (i < rxq_b.size()) ? rxq_b[i] : 32'hFFFF_FFFF;
    return (i < rxq_a.size()) ? rxq_a[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic ss_low(input bit sel);
    sck = cpol;
    wait_clk(HP);
    if (sel) ss_b = 1'b0; else ss_a = 1'b0;
    wait_clk(HP);
  endtask

  task automatic ss_high(input bit sel);
    wait_clk(HP);
    if (sel) ss_b = 1'b1; else ss_a = 1'b1;
    wait_clk(2 * HP);
  endtask

  // Master side of one word (or its first nb bits) for the current cpol/cpha/lsb_first.
  task automatic spi_bits(input bit sel, input int w, input int nb, input int idx);
    m_in[idx] = '0;
    for (int i = 0; i < nb; i++) begin
      int b;
      b = lsb_first ? i : w - 1 - i;
      if (!cpha) begin
        mosi = m_out[idx][b];
        wait_clk(HP);
        m_in[idx][b] = sel ? miso_b : miso_a;
        sck = ~cpol;
        wait_clk(HP);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = m_out[idx][b];
        wait_clk(HP);
        m_in[idx][b] = sel ? miso_b : miso_a;
        sck = cpol;
        wait_clk(HP);
      end
    end
  endtask

  task automatic run_burst(input bit sel, input int w, input int n);
    ss_low(sel);
    for (int k = 0; k < n; k++) spi_bits(sel, w, w, k);
    ss_high(sel);
  endtask

  typedef struct {
    bit cpol;
    bit cpha;
    int exp_und;
  } mode_vec_t;

  initial begin
    mode_vec_t   mv [4];
    logic [31:0] buf_w [4];
    logic [31:0] mst_w [4];
    logic [31:0] fw [4];
    int base, u0, n, nfeed, w;
    bit sel;
    logic [31:0] mask;

    // cpha=0 bursts end with one extra word start (trailing edge after the last sample).
    mv[0] = '{cpol: 1'b0, cpha: 1'b0, exp_und: 1};
    mv[1] = '{cpol: 1'b0, cpha: 1'b1, exp_und: 0};
    mv[2] = '{cpol: 1'b1, cpha: 1'b0, exp_und: 1};
    mv[3] = '{cpol: 1'b1, cpha: 1'b1, exp_und: 0};
    buf_w = '{32'h00, 32'hAA, 32'hFF, 32'hBE};
    mst_w = '{32'hAA, 32'hFF, 32'h00, 32'hAA};

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    wait_clk(4);
    check("rst_miso_a", {31'b0, miso_a}, 32'h0);
    check("rst_tx_ready_a", {31'b0, ifa.tx_ready}, 32'h1);
    check("rst_rx_valid_a", {31'b0, ifa.rx_valid}, 32'h0);
    check("rst_rx_data_a", {24'b0, ifa.rx_data}, 32'h0);
    check("rst_underrun_a", {31'b0, ifa.underrun}, 32'h0);
    check("rst_miso_b", {31'b0, miso_b}, 32'h0);
    check("rst_tx_ready_b", {31'b0, ifb.tx_ready}, 32'h1);
    rst = 1'b0;
    wait_clk(4);

    // All four modes, 4-word burst on the 8-bit slave.
    for (int m = 0; m < 4; m++) begin
      cpol = mv[m].cpol; cpha = mv[m].cpha; lsb_first = 1'b0;
      for (int k = 0; k < 4; k++) begin
        push(1'b0, buf_w[k]);
        m_out[k] = mst_w[k];
      end
      base = rxq_a.size(); u0 = und_a;
      run_burst(1'b0, 8, 4);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("mode%0d_rx%0d", m, k), rx_at(1'b0, base + k), mst_w[k]);
        check($sformatf("mode%0d_miso%0d", m, k), m_in[k], buf_w[k]);
      end
      check($sformatf("mode%0d_rx_count", m), 32'(rxq_a.size() - base), 32'd4);
      check($sformatf("mode%0d_underruns", m), 32'(und_a - u0), 32'(mv[m].exp_und));
      check($sformatf("mode%0d_tx_ready", m), {31'b0, ifa.tx_ready}, 32'h1);
    end

    // LSB-first, 16-bit.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b1;
    push(1'b1, 32'hBEEF);
    m_out[0] = 32'h1234;
    base = rxq_b.size();
    run_burst(1'b1, 16, 1);
    check("lsb16_rx", rx_at(1'b1, base), 32'h1234);
    check("lsb16_miso", m_in[0], 32'hBEEF);

    // Underrun (mode 1): empty buffer at word start, word accepted mid-word.
    cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0;
    m_out[0] = 32'h5A;
    u0 = und_a;
    fork
      run_burst(1'b0, 8, 1);
      begin
        wait_clk(HP * 6);
        push(1'b0, 32'h3C);
        wait_clk(4);
        check("und_tx_ready_mid", {31'b0, ifa.tx_ready}, 32'h0);
      end
    join
    check("und_miso", m_in[0], 32'hA5);
    check("und_pulses", 32'(und_a - u0), 32'd1);
    check("und_tx_ready_held", {31'b0, ifa.tx_ready}, 32'h0);
    u0 = und_a; base = rxq_a.size();
    m_out[0] = 32'hC3;
    run_burst(1'b0, 8, 1);
    check("und_next_miso", m_in[0], 32'h3C);
    check("und_next_pulses", 32'(und_a - u0), 32'd0);
    check("und_next_tx_ready", {31'b0, ifa.tx_ready}, 32'h1);
    check("und_next_rx", rx_at(1'b0, base), 32'hC3);

    // ss raised after 3 bits, then a full word.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    push(1'b0, 32'h11);
    wait_clk(4);
    base = rxq_a.size();
    m_out[0] = 32'hF0;
    ss_low(1'b0);
    spi_bits(1'b0, 8, 3, 0);
    push(1'b0, 32'h3C);
    wait_clk(4);
    ss_high(1'b0);
    check("partial_no_rx", 32'(rxq_a.size() - base), 32'd0);
    check("partial_buf_kept", {31'b0, ifa.tx_ready}, 32'h0);
    m_out[0] = 32'h5C;
    run_burst(1'b0, 8, 1);
    check("partial_rx_count", 32'(rxq_a.size() - base), 32'd1);
    check("partial_rx", rx_at(1'b0, base), 32'h5C);
    check("partial_miso", m_in[0], 32'h3C);

    // Reset in the middle of a word with a TX word buffered.
    push(1'b0, 32'h77);
    wait_clk(4);
    m_out[0] = 32'h5A;
    ss_low(1'b0);
    spi_bits(1'b0, 8, 3, 0);
    push(1'b0, 32'h66);
    wait_clk(4);
    check("rstmid_buf_full", {31'b0, ifa.tx_ready}, 32'h0);
    rst = 1'b1;
    wait_clk(1);
    check("rstmid_miso", {31'b0, miso_a}, 32'h0);
    check("rstmid_tx_ready", {31'b0, ifa.tx_ready}, 32'h1);
    check("rstmid_rx_valid", {31'b0, ifa.rx_valid}, 32'h0);
    check("rstmid_rx_data", {24'b0, ifa.rx_data}, 32'h0);
    rst = 1'b0;
    ss_high(1'b0);
    push(1'b0, 32'h42);
    base = rxq_a.size();
    m_out[0] = 32'h99;
    run_burst(1'b0, 8, 1);
    check("rstmid_after_rx", rx_at(1'b0, base), 32'h99);
    check("rstmid_after_miso", m_in[0], 32'h42);

    // Random bursts against a word-level model: the slave sends queued words in
    // order, the underrun word once the queue runs dry, and the master's words come back.
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      w = sel ? 16 : 8;
      mask = sel ? 32'hFFFF : 32'hFF;
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      lsb_first = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      nfeed = n - $urandom_range(0, 1);
      for (int k = 0; k < n; k++) begin
        m_out[k] = $urandom() & mask;
        fw[k] = $urandom() & mask;
        if (k < nfeed) push(sel, fw[k]);
      end
      base = sel ? rxq_b.size() : rxq_a.size();
      u0 = sel ? und_b : und_a;
      run_burst(sel, w, n);
      for (int k = 0; k < n; k++) begin
        check($sformatf("rnd%0d_rx%0d", it, k), rx_at(sel, base + k), m_out[k]);
        check($sformatf("rnd%0d_miso%0d", it, k), m_in[k],
              (k < nfeed) ? fw[k] : (sel ? 32'h0000 : 32'hA5));
      end
      check($sformatf("rnd%0d_underruns", it), 32'((sel ? und_b : und_a) - u0),
            32'(n + (cpha ? 0 : 1) - nfeed));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
